uart_debug_loader: RTL

Command interpreter sitting directly downstream of the UART receive FIFO and upstream of its transmit FIFO. Pops command bytes from the UART, assembles little-endian 32-bit words and writes them into instruction memory, and starts or single-steps the MIPS core. Every command is acknowledged with a single response byte pushed into the UART transmit FIFO.

---
 rtl/uart_debug_loader_if.sv | 33 +++
 rtl/uart_debug_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_debug_loader_if.sv
// Handshake bundle between the debug loader and its UART FIFOs, instruction memory and core control.
// "master" is the loader side and "slave" is the environment side.
interface uart_debug_loader_if #(
  parameter int DATA_BITS = 8,
  parameter int WORD_BITS = 4 * DATA_BITS,
  parameter int ADDR_BITS = 10
);
  logic                 i_rx_empty;
  logic [DATA_BITS-1:0] i_rx_data;
  logic                 o_rd_uart;
  logic                 i_tx_full;
  logic                 o_wr_uart;
  logic [DATA_BITS-1:0] o_tx_data;
  logic                 i_halt;
  logic                 o_imem_we;
  logic [ADDR_BITS-1:0] o_imem_addr;
  logic [WORD_BITS-1:0] o_imem_data;
  logic                 o_cpu_en;
  logic                 o_step;
  logic                 o_busy;

  modport master (
    input  i_rx_empty, i_rx_data, i_tx_full, i_halt,
    output o_rd_uart, o_wr_uart, o_tx_data, o_imem_we, o_imem_addr,
           o_imem_data, o_cpu_en, o_step, o_busy
  );

  modport slave (
    output i_rx_empty, i_rx_data, i_tx_full, i_halt,
    input  o_rd_uart, o_wr_uart, o_tx_data, o_imem_we, o_imem_addr,
           o_imem_data, o_cpu_en, o_step, o_busy
  );
endinterface

// File: rtl/uart_debug_loader.sv
// UART command interpreter: loads little-endian words into instruction memory,
// runs or single-steps the core, and answers every command with one response byte.
module uart_debug_loader #(
  parameter int DATA_BITS = 8,
  parameter int WORD_BITS = 4 * DATA_BITS,
  parameter int ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  uart_debug_loader_if.master  bus
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, RUN, SEND} state_e;

  localparam logic [DATA_BITS-1:0] CMD_LOAD = DATA_BITS'(8'h4C);
  localparam logic [DATA_BITS-1:0] CMD_RUN  = DATA_BITS'(8'h52);
  localparam logic [DATA_BITS-1:0] CMD_STEP = DATA_BITS'(8'h53);
  localparam logic [DATA_BITS-1:0] RSP_STEP = DATA_BITS'(8'h53);
  localparam logic [DATA_BITS-1:0] RSP_ERR  = DATA_BITS'(8'hEE);
  localparam logic [DATA_BITS-1:0] RSP_LOAD = DATA_BITS'(8'hA5);
  localparam logic [DATA_BITS-1:0] RSP_HALT = DATA_BITS'(8'hD0);

  state_e               state_q;
  logic [DATA_BITS-1:0] cnt_q;
  logic [1:0]           k_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WORD_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] tx_q;
  logic                 we_q;
  logic                 cpu_en_q;
  logic                 step_q;
  logic                 pop_d;

  // Pops are combinational so a byte is consumed in the same cycle it is sampled;
  // held off during reset so no byte is lost while the block is cleared.
  assign pop_d = i_reset && !bus.i_rx_empty &&
                 (state_q == IDLE || state_q == LEN || state_q == DATA);

  assign bus.o_rd_uart   = pop_d;
  assign bus.o_wr_uart   = (state_q == SEND) && !bus.i_tx_full;
  assign bus.o_tx_data   = tx_q;
  assign bus.o_imem_we   = we_q;
  assign bus.o_imem_addr = addr_q;
  assign bus.o_imem_data = data_q;
  assign bus.o_cpu_en    = cpu_en_q;
  assign bus.o_step      = step_q;
  assign bus.o_busy      = (state_q != IDLE);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tx_q     <= '0;
      we_q     <= 1'b0;
      cpu_en_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        IDLE: if (pop_d) begin
          case (bus.i_rx_data)
            CMD_LOAD: state_q <= LEN;
            CMD_RUN: begin
              cpu_en_q <= 1'b1;
              state_q  <= RUN;
            end
            CMD_STEP: begin
              step_q  <= 1'b1;
              tx_q    <= RSP_STEP;
              state_q <= SEND;
            end
            default: begin
              tx_q    <= RSP_ERR;
              state_q <= SEND;
            end
          endcase
        end
        LEN: if (pop_d) begin
          if (bus.i_rx_data == '0) begin
            tx_q    <= RSP_LOAD;
            state_q <= SEND;
          end else begin
            cnt_q   <= bus.i_rx_data;
            addr_q  <= '0;
            k_q     <= '0;
            state_q <= DATA;
          end
        end
        DATA: if (pop_d) begin
          data_q[k_q*DATA_BITS +: DATA_BITS] <= bus.i_rx_data;
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        // k_q has already wrapped to 0 here, ready for the next word
        WRITE: begin
          addr_q <= addr_q + ADDR_BITS'(4);
          cnt_q  <= cnt_q - DATA_BITS'(1);
          if (cnt_q == DATA_BITS'(1)) begin
            tx_q    <= RSP_LOAD;
            state_q <= SEND;
          end else begin
            state_q <= DATA;
          end
        end
        RUN: if (bus.i_halt) begin
          cpu_en_q <= 1'b0;
          tx_q     <= RSP_HALT;
          state_q  <= SEND;
        end
        SEND: if (!bus.i_tx_full) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
